// File: rtl/photon_gate_counter_pkg.sv
// Shared types, default widths and arithmetic helpers for the photon gate counter.
package photon_gate_counter_pkg;

  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_GATE_W    = 24;
  localparam int DEF_IDX_W     = 16;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  // Returns {would_overflow, sum}; the sum clamps at the all-ones value of a w-bit counter.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic inc,
                                          input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (inc && (a == max_v)) return {1'b1, a};
    return {1'b0, a + {63'd0, inc}};
  endfunction

endpackage

// File: rtl/photon_gate_counter_if.sv
// Control, detector and result-handshake bundle between the counter and its host.
interface photon_gate_counter_if #(
  parameter int CNT_WIDTH = 32,
  parameter int GATE_W    = 24,
  parameter int IDX_W     = 16
) ();
  logic                 START_COUNT;
  logic                 PHOTON_IN;
  logic [GATE_W-1:0]    GATE_LEN;
  logic [CNT_WIDTH-1:0] COUNT_OUT;
  logic [IDX_W-1:0]     COUNT_IDX;
  logic                 COUNT_OVF;
  logic                 COUNT_VALID;
  logic                 COUNT_ACK;
  logic                 OVERRUN;
  logic                 BUSY;

  modport master (
    output START_COUNT, PHOTON_IN, GATE_LEN, COUNT_ACK,
    input  COUNT_OUT, COUNT_IDX, COUNT_OVF, COUNT_VALID, OVERRUN, BUSY
  );

  modport slave (
    input  START_COUNT, PHOTON_IN, GATE_LEN, COUNT_ACK,
    output COUNT_OUT, COUNT_IDX, COUNT_OVF, COUNT_VALID, OVERRUN, BUSY
  );
endinterface

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus a third flop for one-cycle rising-edge detection.
module pulse_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic SIG_IN,
  output logic RISE
);
  logic [2:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], SIG_IN};
  end

  assign RISE = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/photon_gate_counter.sv
// Counts synchronized photon pulses in back-to-back gate windows and hands each
// window result to the host through a one-deep valid/ack buffer.
module photon_gate_counter
  import photon_gate_counter_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int GATE_W    = DEF_GATE_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input logic CLK,
  input logic RST,
  photon_gate_counter_if.slave bus
);
  state_t               state;
  logic [GATE_W-1:0]    gate_cnt;
  logic [GATE_W-1:0]    gate_reload;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] acc_add;
  logic                 acc_sat;
  logic                 add_ovf;
  logic [64:0]          acc_sum;
  logic [IDX_W-1:0]     win_idx;
  logic                 photon_edge;
  logic [CNT_WIDTH-1:0] count_out;
  logic [IDX_W-1:0]     count_idx;
  logic                 count_ovf;
  logic                 count_valid;
  logic                 overrun;
  logic                 busy;

  pulse_sync_edge u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .SIG_IN (bus.PHOTON_IN),
    .RISE   (photon_edge)
  );

  // A zero gate length behaves as a one-cycle window.
  assign gate_reload = (bus.GATE_LEN == '0) ? '0 : bus.GATE_LEN - GATE_W'(1);
  assign acc_sum     = sat_add(64'(acc), photon_edge, CNT_WIDTH);
  assign acc_add     = CNT_WIDTH'(acc_sum);
  assign add_ovf     = acc_sum[64];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      acc         <= '0;
      acc_sat     <= 1'b0;
      win_idx     <= '0;
      count_out   <= '0;
      count_idx   <= '0;
      count_ovf   <= 1'b0;
      count_valid <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (count_valid && bus.COUNT_ACK) count_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START_COUNT) begin
            state    <= COUNT;
            busy     <= 1'b1;
            gate_cnt <= gate_reload;
            acc      <= '0;
            acc_sat  <= 1'b0;
            win_idx  <= '0;
            overrun  <= 1'b0;
          end
        end
        COUNT: begin
          // Dropping the run level wins over a window ending in the same cycle.
          if (!bus.START_COUNT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gate_cnt == '0) begin
            count_out   <= acc_add;
            count_ovf   <= acc_sat | add_ovf;
            count_idx   <= win_idx;
            count_valid <= 1'b1;
            if (count_valid && !bus.COUNT_ACK) overrun <= 1'b1;
            win_idx     <= win_idx + IDX_W'(1);
            acc         <= '0;
            acc_sat     <= 1'b0;
            gate_cnt    <= gate_reload;
          end else begin
            acc      <= acc_add;
            acc_sat  <= acc_sat | add_ovf;
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.COUNT_OUT   = count_out;
  assign bus.COUNT_IDX   = count_idx;
  assign bus.COUNT_OVF   = count_ovf;
  assign bus.COUNT_VALID = count_valid;
  assign bus.OVERRUN     = overrun;
  assign bus.BUSY        = busy;
endmodule

// File: tb/tb_photon_gate_counter.sv
// Bench: a full-width and a narrow (4-bit count, 2-bit index) counter share one
// stimulus stream and are checked every cycle against a window-level model.
module tb_photon_gate_counter;
  localparam int MAXC = 16384;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        photon = 1'b0;
  logic        ack = 1'b0;
  logic [23:0] glen = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  photon_gate_counter_if #(.CNT_WIDTH(32), .GATE_W(24), .IDX_W(16)) bus_a ();
  photon_gate_counter_if #(.CNT_WIDTH(4),  .GATE_W(24), .IDX_W(2))  bus_b ();

  assign bus_a.START_COUNT = start;
  assign bus_a.PHOTON_IN   = photon;
  assign bus_a.GATE_LEN    = glen;
  assign bus_a.COUNT_ACK   = ack;
  assign bus_b.START_COUNT = start;
  assign bus_b.PHOTON_IN   = photon;
  assign bus_b.GATE_LEN    = glen;
  assign bus_b.COUNT_ACK   = ack;

  photon_gate_counter #(.CNT_WIDTH(32), .GATE_W(24), .IDX_W(16)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a.slave)
  );

  photon_gate_counter #(.CNT_WIDTH(4), .GATE_W(24), .IDX_W(2)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Window-level model: raw photon samples per cycle, unbounded counts and indices;
  // widths are applied only when the expectation is formed.
  bit          ph [0:MAXC-1];
  int unsigned cyc = 0;
  bit          m_ok = 0;
  bit          running = 0;
  int unsigned win_end = 0;
  int unsigned win_idx = 0;
  int unsigned cnt = 0;
  int unsigned e_cnt = 0;
  int unsigned e_idx = 0;
  bit          e_valid = 0;
  bit          e_ovr = 0;
  bit          e_busy = 0;

  function automatic int unsigned eff_len(input logic [23:0] g);
    return (g == 0) ? 1 : int'(g);
  endfunction

  always @(posedge CLK) begin
    bit edge_now;
    bit accept;
    bit latched;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget got %0d want <%0d", cyc, MAXC);
      $fatal(1);
    end
    ph[cyc] = photon;
    edge_now = (cyc >= 3) && ph[cyc-2] && !ph[cyc-3];
    if (RST) begin
      m_ok = 1; running = 0; cnt = 0; win_idx = 0;
      e_cnt = 0; e_idx = 0; e_valid = 0; e_ovr = 0; e_busy = 0;
      for (int k = 0; k < 3; k++) if (cyc >= k) ph[cyc-k] = 0;
    end else begin
      accept  = e_valid && ack;
      latched = 0;
      if (!running) begin
        if (start) begin
          running = 1; cnt = 0; win_idx = 0; e_ovr = 0;
          win_end = cyc + eff_len(glen);
        end
      end else if (!start) begin
        running = 0;
      end else begin
        cnt += edge_now;
        if (cyc == win_end) begin
          if (e_valid && !ack) e_ovr = 1;
          e_cnt = cnt; e_idx = win_idx; e_valid = 1; latched = 1;
          win_idx++; cnt = 0;
          win_end = cyc + eff_len(glen);
        end
      end
      if (accept && !latched) e_valid = 0;
      e_busy = running;
    end
  end

  always @(negedge CLK) begin
    if (m_ok) begin
      chk("a_out",     64'(bus_a.COUNT_OUT),   64'(e_cnt));
      chk("a_idx",     64'(bus_a.COUNT_IDX),   64'(e_idx % 65536));
      chk("a_ovf",     64'(bus_a.COUNT_OVF),   64'(0));
      chk("a_valid",   64'(bus_a.COUNT_VALID), 64'(e_valid));
      chk("a_overrun", 64'(bus_a.OVERRUN),     64'(e_ovr));
      chk("a_busy",    64'(bus_a.BUSY),        64'(e_busy));
      chk("b_out",     64'(bus_b.COUNT_OUT),   64'((e_cnt > 15) ? 15 : e_cnt));
      chk("b_idx",     64'(bus_b.COUNT_IDX),   64'(e_idx % 4));
      chk("b_ovf",     64'(bus_b.COUNT_OVF),   64'(e_cnt > 15));
      chk("b_valid",   64'(bus_b.COUNT_VALID), 64'(e_valid));
      chk("b_overrun", 64'(bus_b.OVERRUN),     64'(e_ovr));
      chk("b_busy",    64'(bus_b.BUSY),        64'(e_busy));
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; start = 0; photon = 0; ack = 0;
    tick();
    RST = 0;
  endtask

  initial begin
    tick();
    // Three pulses in a 10-cycle window, result after the 11th edge, then ack.
    do_reset();
    glen = 24'd10; start = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 10) chk("t1_valid_early", 64'(bus_a.COUNT_VALID), 64'd0);
      if (i == 11) begin
        chk("t1_valid", 64'(bus_a.COUNT_VALID), 64'd1);
        chk("t1_out",   64'(bus_a.COUNT_OUT),   64'd3);
        chk("t1_idx",   64'(bus_a.COUNT_IDX),   64'd0);
      end
      if (i == 12) chk("t1_acked", 64'(bus_a.COUNT_VALID), 64'd0);
      photon = (i == 1 || i == 3 || i == 5);
      ack    = (i == 11);
    end

    // Saturation of the narrow counter, then recovery in the following window.
    do_reset();
    glen = 24'd50; start = 1;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 51) begin
        chk("t2_b_out", 64'(bus_b.COUNT_OUT), 64'd15);
        chk("t2_b_ovf", 64'(bus_b.COUNT_OVF), 64'd1);
        chk("t2_a_out", 64'(bus_a.COUNT_OUT), 64'd20);
      end
      if (i == 101) begin
        chk("t2_b_out2", 64'(bus_b.COUNT_OUT), 64'd2);
        chk("t2_b_ovf2", 64'(bus_b.COUNT_OVF), 64'd0);
      end
      photon = (i < 40 && (i % 2 == 1)) || i == 55 || i == 57;
    end

    // Run dropped mid-window discards the partial count; restart begins at index 0.
    do_reset();
    glen = 24'd20; start = 1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (i == 12) begin
        chk("t3_busy",  64'(bus_a.BUSY),        64'd0);
        chk("t3_valid", 64'(bus_a.COUNT_VALID), 64'd0);
      end
      if (i == 15) chk("t3_ovr", 64'(bus_a.OVERRUN), 64'd0);
      if (i == 35) begin
        chk("t3_valid2", 64'(bus_a.COUNT_VALID), 64'd1);
        chk("t3_idx",    64'(bus_a.COUNT_IDX),   64'd0);
      end
      photon = (i < 10 && (i % 2 == 1));
      start  = (i < 11 || i >= 14);
    end

    // Unacked results overrun; ack coinciding with a new result; index wrap.
    do_reset();
    glen = 24'd4; start = 1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 13) begin
        chk("t4_idx", 64'(bus_a.COUNT_IDX), 64'd2);
        chk("t4_ovr", 64'(bus_a.OVERRUN),   64'd1);
      end
      if (i == 17) begin
        chk("t4_valid", 64'(bus_a.COUNT_VALID), 64'd1);
        chk("t4_idx3",  64'(bus_a.COUNT_IDX),   64'd3);
        chk("t4_ovr3",  64'(bus_a.OVERRUN),     64'd1);
      end
      if (i == 21) begin
        chk("t4_b_wrap", 64'(bus_b.COUNT_IDX), 64'd0);
        chk("t4_a_idx4", 64'(bus_a.COUNT_IDX), 64'd4);
      end
      ack = (i == 16);
    end
    ack = 0;

    // Zero gate length: one-cycle windows, edge counted in the window it lands in.
    do_reset();
    glen = 24'd0; start = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        chk("t5_out", 64'(bus_a.COUNT_OUT), 64'd1);
        chk("t5_idx", 64'(bus_a.COUNT_IDX), 64'd5);
      end
      if (i == 8) chk("t5_out_next", 64'(bus_a.COUNT_OUT), 64'd0);
      photon = (i == 4);
    end

    // Reset while counting clears every output.
    do_reset();
    glen = 24'd4; start = 1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 11) chk("t6_out_pre", 64'(bus_a.COUNT_OUT), 64'd2);
      if (i == 13) begin
        chk("t6_out",  64'(bus_a.COUNT_OUT),   64'd0);
        chk("t6_val",  64'(bus_a.COUNT_VALID), 64'd0);
        chk("t6_ovr",  64'(bus_a.OVERRUN),     64'd0);
        chk("t6_busy", 64'(bus_a.BUSY),        64'd0);
      end
      photon = (i < 8 && (i % 2 == 1));
      RST    = (i == 12);
    end
    RST = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0)
        glen = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 40)) : 24'($urandom_range(0, 9));
      photon = ($urandom_range(0, 2) != 0) ? ~photon : photon;
      ack    = ($urandom_range(0, 3) == 0);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
